hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller. It produces the stall, flush and forwarding controls that the fetch, decode and execute pipeline registers consume. Those controls include the `flush_e` clear of the execute-stage register. It also tracks occupancy of the multi-cycle multiply/divide unit (MDU) so that HI/LO consumers and back-to-back MDU ops wait. The block sits beside the datapath, takes register indices and control bits from D/E/M/W, and returns the controls combinationally within the same cycle.

## Interface
- `MDU_CYCLES`, default 32: cycles the MDU stays busy after an op enters E; legal range 1..63.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `rs_d_i`, `rt_d_i`  in  5 each  source registers of the instruction in D.
- `branch_d_i`  in  1  D holds a branch compared in D.
- `pc_src_d_i`  in  1  branch/jump taken, resolved in D.
- `hilo_read_d_i`  in  1  D holds mfhi/mflo.
- `mdu_op_d_i`  in  1  D holds mult/multu/div/divu.
- `rs_e_i`, `rt_e_i`, `write_reg_e_i`  in  5 each  E-stage register indices.
- `reg_write_e_i`, `mem_to_reg_e_i`, `mdu_start_e_i`  in  1 each  E-stage controls.
- `write_reg_m_i`  in  5  M-stage destination register.
- `reg_write_m_i`, `mem_to_reg_m_i`  in  1 each  M-stage controls.
- `write_reg_w_i`  in  5  W-stage destination register.
- `reg_write_w_i`  in  1  W-stage control.
- `stall_f_o`, `stall_d_o`  out  1 each  hold the F and D registers.
- `flush_d_o`, `flush_e_o`  out  1 each  clear the D and E registers.
- `forward_a_d_o`, `forward_b_d_o`  out  1 each  select the M result for the D comparator.
- `forward_a_e_o`, `forward_b_e_o`  out  2 each  ALU operand select, using `fwd_sel_e`.
- `mdu_busy_o`  out  1  MDU occupied.
- `stall_cycles_o`, `flush_cycles_o`  out  32 each  performance counters.

## Operation
- A register match means the indices are equal and the index is nonzero. Register 0 never matches.
- Forwarding in E, per operand, with priority M over W:
  - `FWD_MEM` (2'b10) if `reg_write_m_i` and `write_reg_m_i` matches `rs_e_i` (or `rt_e_i`).
  - Otherwise `FWD_WB` (2'b01) on the same test against W.
  - Otherwise `FWD_NONE` (2'b00).
- Forwarding in D: `forward_a_d_o` = `reg_write_m_i` and `write_reg_m_i` matches `rs_d_i`. `forward_b_d_o` is the same test against `rt_d_i`.
- Load-use stall: `mem_to_reg_e_i` and `write_reg_e_i` matches `rs_d_i` or `rt_d_i`.
- Branch stall: `branch_d_i` and one of the following:
  - `reg_write_e_i` and `write_reg_e_i` matches `rs_d_i`/`rt_d_i`;
  - `mem_to_reg_m_i` and `write_reg_m_i` matches `rs_d_i`/`rt_d_i`.
- MDU stall: (`hilo_read_d_i` or `mdu_op_d_i`) and (`mdu_busy_o` or `mdu_start_e_i`).
- Combined stall: `stall` = load-use OR branch OR MDU stall. `stall_f_o` = `stall_d_o` = `flush_e_o` = `stall`.
- `flush_d_o` = `pc_src_d_i` and not `stall`.
- MDU counter, 6-bit `cnt`:
  - Two states: IDLE (`cnt`=0) and BUSY (`cnt`≠0). `mdu_busy_o` = (`cnt`≠0).
  - IDLE with `mdu_start_e_i`: load `MDU_CYCLES`.
  - BUSY: decrement each cycle.
  - `mdu_start_e_i` while BUSY is ignored; the counter keeps decrementing. A bench assertion flags it as illegal, because the MDU stall prevents it.

## Timing
- All stall, flush and forward outputs are combinational from inputs and `cnt`, valid in the same cycle.
- `cnt` updates on the rising edge of `clk_i`.
- Start sampled at edge N puts `mdu_busy_o` high for edges N+1 .. N+`MDU_CYCLES`. It is low again after `MDU_CYCLES` decrements.
- mfhi in D is released in the first cycle with `cnt`=0.
- Reset (`rst_ni` low, asynchronous, any time including mid-count):
  - `cnt`=0 and both counters = 0.
  - Outputs then follow the inputs combinationally, so with all inputs 0 every output is 0.
- Simultaneous stall and `pc_src_d_i`: the stall wins, so `flush_d_o`=0. The branch re-resolves next cycle.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles_o` increments every cycle `stall`=1.
  - `flush_cycles_o` increments every cycle `flush_d_o`=1.
  - Both saturate at 32'hFFFF_FFFF.
- `HAZARD_PERF_CNT_EN` undefined: both outputs are tied to 0 and no counter flops exist.

## Structure
- Shared `pipeline_pkg` holds:
  - typedef enum logic [1:0] `fwd_sel_e` {`FWD_NONE`, `FWD_WB`, `FWD_MEM`};
  - constant `REG_ZERO` = 5'd0.
- One sub-module, `hazard_mdu_tracker`: the counter plus `mdu_busy_o`, parameterised by `MDU_CYCLES`.
- Forwarding and stall logic live in `hazard_unit`.

## Test plan
- Load-use: E holds lw with `write_reg_e_i`=8 and `mem_to_reg_e_i`=1; `rs_d_i`=8. Expect `stall_f_o`=`stall_d_o`=`flush_e_o`=1 for one cycle, then all 0 once the lw moves to M.
- Forward priority: `write_reg_m_i`=`write_reg_w_i`=5, both write enables 1, `rs_e_i`=5. Expect `forward_a_e_o`=2'b10. With `reg_write_m_i`=0, expect 2'b01. With `rs_e_i`=0, expect 2'b00.
- MDU, `MDU_CYCLES`=4: `mdu_start_e_i` pulse, then `hilo_read_d_i`=1 held. Expect stall for the start cycle plus 4 busy cycles, then release.
- Branch: `branch_d_i`=1 and `pc_src_d_i`=1, with `reg_write_e_i`=1 and `write_reg_e_i`=`rt_d_i`=3. Expect stall=1 and `flush_d_o`=0. Next cycle, with no hazard, expect `flush_d_o`=1.
- Reset mid-count: assert `rst_ni`=0 at `cnt`=2. Expect `mdu_busy_o`=0 immediately, without waiting for a clock edge.
- With `HAZARD_PERF_CNT_EN`: 3 stall cycles and 1 flush cycle give `stall_cycles_o`=3 and `flush_cycles_o`=1. Without the macro, both stay 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding select encoding, the zero register, and the register-match rule.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Register 0 is hardwired, so it never carries a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_mdu_tracker.sv
// MDU occupancy counter: loads MDU_CYCLES on a start from idle, then counts down to idle.
module hazard_mdu_tracker #(
  parameter int MDU_CYCLES = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic busy_o
);

  logic [5:0] cnt_q, cnt_d;

  // A start while busy is dropped; the in-flight count runs to completion.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != 6'd0)  cnt_d = cnt_q - 6'd1;
    else if (start_i)   cnt_d = 6'(MDU_CYCLES);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= 6'd0;
    else         cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != 6'd0);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stall/flush/forward controls plus MDU occupancy.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int MDU_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  rs_d_i,
  input  logic [4:0]  rt_d_i,
  input  logic        branch_d_i,
  input  logic        pc_src_d_i,
  input  logic        hilo_read_d_i,
  input  logic        mdu_op_d_i,
  input  logic [4:0]  rs_e_i,
  input  logic [4:0]  rt_e_i,
  input  logic [4:0]  write_reg_e_i,
  input  logic        reg_write_e_i,
  input  logic        mem_to_reg_e_i,
  input  logic        mdu_start_e_i,
  input  logic [4:0]  write_reg_m_i,
  input  logic        reg_write_m_i,
  input  logic        mem_to_reg_m_i,
  input  logic [4:0]  write_reg_w_i,
  input  logic        reg_write_w_i,
  output logic        stall_f_o,
  output logic        stall_d_o,
  output logic        flush_d_o,
  output logic        flush_e_o,
  output logic        forward_a_d_o,
  output logic        forward_b_d_o,
  output fwd_sel_e    forward_a_e_o,
  output fwd_sel_e    forward_b_e_o,
  output logic        mdu_busy_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_cycles_o
);

  logic lu_stall, br_stall, mdu_stall, stall;

  hazard_mdu_tracker #(.MDU_CYCLES(MDU_CYCLES)) u_mdu (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (mdu_start_e_i),
    .busy_o  (mdu_busy_o)
  );

  function automatic fwd_sel_e fwd_e(input logic [4:0] src);
    if (reg_write_m_i && reg_match(write_reg_m_i, src))      return FWD_MEM;
    else if (reg_write_w_i && reg_match(write_reg_w_i, src)) return FWD_WB;
    else                                                     return FWD_NONE;
  endfunction

  always_comb begin
    forward_a_e_o = fwd_e(rs_e_i);
    forward_b_e_o = fwd_e(rt_e_i);
    forward_a_d_o = reg_write_m_i && reg_match(write_reg_m_i, rs_d_i);
    forward_b_d_o = reg_write_m_i && reg_match(write_reg_m_i, rt_d_i);

    lu_stall = mem_to_reg_e_i &&
               (reg_match(write_reg_e_i, rs_d_i) || reg_match(write_reg_e_i, rt_d_i));
    // The D comparator can take an ALU result from M but not a load still in M.
    br_stall = branch_d_i &&
               ((reg_write_e_i  && (reg_match(write_reg_e_i, rs_d_i) || reg_match(write_reg_e_i, rt_d_i))) ||
                (mem_to_reg_m_i && (reg_match(write_reg_m_i, rs_d_i) || reg_match(write_reg_m_i, rt_d_i))));
    mdu_stall = (hilo_read_d_i || mdu_op_d_i) && (mdu_busy_o || mdu_start_e_i);
    stall     = lu_stall || br_stall || mdu_stall;

    stall_f_o = stall;
    stall_d_o = stall;
    flush_e_o = stall;
    flush_d_o = pc_src_d_i && !stall;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall     && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_d_o && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_cycles_o = flush_cnt_q;
`else
  assign stall_cycles_o = 32'd0;
  assign flush_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Table-driven and sequence checks for hazard_unit with MDU_CYCLES=4; expectations queued per vector.
module tb_hazard_unit;
  import pipeline_pkg::*;

  typedef struct packed {
    logic [4:0] rs_d, rt_d;
    logic       br, pcs, hilo, mduop;
    logic [4:0] rs_e, rt_e, wr_e;
    logic       rw_e, m2r_e, mst_e;
    logic [4:0] wr_m;
    logic       rw_m, m2r_m;
    logic [4:0] wr_w;
    logic       rw_w;
  } in_t;

  typedef struct packed {
    logic       stall, flush_d, fad, fbd;
    logic [1:0] fae, fbe;
    logic       busy;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  in_t         di = '0;
  logic        stall_f, stall_d, flush_d, flush_e, fad, fbd, busy;
  logic [1:0]  fae, fbe;
  logic [31:0] stall_cyc, flush_cyc;

  int   nvec = 0, nmis = 0;
  exp_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  hazard_unit #(.MDU_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rs_d_i(di.rs_d), .rt_d_i(di.rt_d), .branch_d_i(di.br), .pc_src_d_i(di.pcs),
    .hilo_read_d_i(di.hilo), .mdu_op_d_i(di.mduop),
    .rs_e_i(di.rs_e), .rt_e_i(di.rt_e), .write_reg_e_i(di.wr_e),
    .reg_write_e_i(di.rw_e), .mem_to_reg_e_i(di.m2r_e), .mdu_start_e_i(di.mst_e),
    .write_reg_m_i(di.wr_m), .reg_write_m_i(di.rw_m), .mem_to_reg_m_i(di.m2r_m),
    .write_reg_w_i(di.wr_w), .reg_write_w_i(di.rw_w),
    .stall_f_o(stall_f), .stall_d_o(stall_d), .flush_d_o(flush_d), .flush_e_o(flush_e),
    .forward_a_d_o(fad), .forward_b_d_o(fbd), .forward_a_e_o(fae), .forward_b_e_o(fbe),
    .mdu_busy_o(busy), .stall_cycles_o(stall_cyc), .flush_cycles_o(flush_cyc)
  );

  // A start while the MDU is busy is illegal: the MDU stall should have held it in D.
  always @(posedge clk)
    if (rst_n && di.mst_e && busy) begin
      $display("FAIL mdu_start_while_busy at %0t", $time);
      nmis++;
    end

  task automatic check_out(input string name);
    exp_t e, a;
    nvec++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", name);
      nmis++;
      return;
    end
    e = sb.pop_front();
    // stall_f/stall_d/flush_e must all equal the combined stall
    a = '{stall: stall_f, flush_d: flush_d, fad: fad, fbd: fbd, fae: fae, fbe: fbe, busy: busy};
    if (a !== e || stall_d !== e.stall || flush_e !== e.stall) begin
      $display("FAIL %s: got stall=%b/%b/%b flush_d=%b fad=%b fbd=%b fae=%b fbe=%b busy=%b, want stall=%b flush_d=%b fad=%b fbd=%b fae=%b fbe=%b busy=%b",
               name, stall_f, stall_d, flush_e, flush_d, fad, fbd, fae, fbe, busy,
               e.stall, e.flush_d, e.fad, e.fbd, e.fae, e.fbe, e.busy);
      nmis++;
    end
  endtask

  task automatic apply(input in_t i, input exp_t e, input string name);
    @(negedge clk);
    di = i;
    sb.push_back(e);
    #2;
    check_out(name);
  endtask

  task automatic addv(input in_t i, input exp_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    vecs.push_back(v);
  endtask

  in_t  i;
  exp_t e;

  initial begin
    // ---- reset state: all inputs 0, all outputs 0 ----
    #3;
    sb.push_back('0);
    check_out("reset_outputs");
    nvec++;
    if (stall_cyc !== 32'd0 || flush_cyc !== 32'd0) begin
      $display("FAIL reset_perf: got %0d/%0d want 0/0", stall_cyc, flush_cyc);
      nmis++;
    end
    @(negedge clk);
    rst_n = 1'b1;

    // ---- combinational table ----
    addv('0, '0);
    i = '0; i.m2r_e = 1; i.rw_e = 1; i.wr_e = 8; i.rs_d = 8;
    e = '0; e.stall = 1;                                   addv(i, e);
    i = '0; i.m2r_e = 1; i.rw_e = 1; i.wr_e = 8; i.rt_d = 8;
    e = '0; e.stall = 1;                                   addv(i, e);
    i = '0; i.m2r_e = 1; i.rw_e = 1;                       addv(i, '0);
    i = '0; i.rw_m = 1; i.rw_w = 1; i.wr_m = 5; i.wr_w = 5; i.rs_e = 5;
    e = '0; e.fae = 2'b10;                                 addv(i, e);
    i.rw_m = 0; e.fae = 2'b01;                             addv(i, e);
    i.rs_e = 0; e.fae = 2'b00;                             addv(i, e);
    i = '0; i.rw_m = 1; i.wr_m = 6; i.rw_w = 1; i.wr_w = 9; i.rs_e = 9; i.rt_e = 6;
    e = '0; e.fae = 2'b01; e.fbe = 2'b10;                  addv(i, e);
    i = '0; i.rw_m = 1; i.wr_m = 7; i.rs_d = 7; i.rt_d = 7;
    e = '0; e.fad = 1; e.fbd = 1;                          addv(i, e);
    i = '0; i.rw_m = 1; i.wr_m = 0;                        addv(i, '0);
    i = '0; i.br = 1; i.rw_m = 1; i.m2r_m = 1; i.wr_m = 4; i.rs_d = 4;
    e = '0; e.stall = 1; e.fad = 1;                        addv(i, e);
    i.m2r_m = 0; e.stall = 0;                              addv(i, e);
    i = '0; i.rw_e = 1; i.wr_e = 3; i.rs_d = 3;            addv(i, '0);
    i = '0; i.hilo = 1; i.mduop = 0;                       addv(i, '0);
    i = '0; i.pcs = 1; e = '0; e.flush_d = 1;              addv(i, e);
    foreach (vecs[k]) apply(vecs[k].i, vecs[k].e, $sformatf("vec%0d", k));

    // ---- load-use then lw in M ----
    i = '0; i.m2r_e = 1; i.rw_e = 1; i.wr_e = 8; i.rs_d = 8;
    e = '0; e.stall = 1;                                   apply(i, e, "lu_stall");
    i = '0; i.m2r_m = 1; i.rw_m = 1; i.wr_m = 8; i.rs_d = 8;
    e = '0; e.fad = 1;                                     apply(i, e, "lu_release");

    // ---- branch: stall beats flush, then flush next cycle ----
    i = '0; i.br = 1; i.pcs = 1; i.rw_e = 1; i.wr_e = 3; i.rt_d = 3;
    e = '0; e.stall = 1;                                   apply(i, e, "br_stall");
    i = '0; i.br = 1; i.pcs = 1;
    e = '0; e.flush_d = 1;                                 apply(i, e, "br_flush");

    // ---- MDU: start cycle + 4 busy cycles stalled, then release ----
    i = '0; i.mst_e = 1; i.hilo = 1;
    e = '0; e.stall = 1;                                   apply(i, e, "mdu_start");
    i = '0; i.hilo = 1;
    e = '0; e.stall = 1; e.busy = 1;
    for (int k = 0; k < 4; k++) apply(i, e, $sformatf("mdu_busy%0d", k));
    apply(i, '0, "mdu_release");
    i = '0; i.mduop = 1; i.mst_e = 1;
    e = '0; e.stall = 1;                                   apply(i, e, "mdu_b2b_start");
    i = '0; i.mduop = 1;
    e = '0; e.stall = 1; e.busy = 1;
    for (int k = 0; k < 4; k++) apply(i, e, $sformatf("mdu_b2b%0d", k));
    apply('0, '0, "mdu_b2b_release");

    // ---- async reset with cnt=2 ----
    i = '0; i.mst_e = 1;                                   apply(i, '0, "rst_start");
    e = '0; e.busy = 1;
    apply('0, e, "rst_cnt4");
    apply('0, e, "rst_cnt3");
    apply('0, e, "rst_cnt2");
    rst_n = 1'b0;
    #1;
    sb.push_back('0);
    check_out("rst_async_busy");
    @(negedge clk);
    rst_n = 1'b1;

    // ---- perf counters: 3 stall cycles, 1 flush cycle ----
    i = '0; i.m2r_e = 1; i.wr_e = 8; i.rs_d = 8;
    e = '0; e.stall = 1;
    for (int k = 0; k < 3; k++) apply(i, e, $sformatf("perf_stall%0d", k));
    i = '0; i.pcs = 1; e = '0; e.flush_d = 1;              apply(i, e, "perf_flush");
    apply('0, '0, "perf_idle");
    nvec++;
`ifdef HAZARD_PERF_CNT_EN
    if (stall_cyc !== 32'd3 || flush_cyc !== 32'd1) begin
      $display("FAIL perf_counts: got stall=%0d flush=%0d want 3/1", stall_cyc, flush_cyc);
      nmis++;
    end
`else
    if (stall_cyc !== 32'd0 || flush_cyc !== 32'd0) begin
      $display("FAIL perf_counts: got stall=%0d flush=%0d want 0/0", stall_cyc, flush_cyc);
      nmis++;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
